ps2_key_controller: RTL
=======================

// Module: ps2_key_controller
// PURPOSE
//  Synchronous PS/2 keyboard front-end controller for the MIPS system: oversamples raw ps2 clk/data on the
//  system clock, sequences 11-bit frame reception with parity/stop/timeout checking, folds E0/F0 prefix
//  bytes into single key events, and buffers events in a small FIFO read by the CPU's I/O port.
//  Replaces edge-clocked keycode capture; everything runs in the clk domain.
// PARAMETERS
//  FILT_LEN     8      consecutive equal samples required before a filtered line changes (>=2)
//  TIMEOUT_CYC  50000  clk cycles allowed between filtered ps2 clk falls inside a frame (1 ms @ 50 MHz)
//  FIFO_DEPTH   4      event FIFO entries; power of two, >=2
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  ps2_clk      in   1   raw keyboard clock (async)
//  ps2_data     in   1   raw keyboard data (async)
//  rd_en        in   1   pop head event when ev_valid=1; ignored when empty
//  ev_valid     out  1   FIFO non-empty
//  ev_data      out  10  head event {brk, ext, code[7:0]}, first-word-fall-through
//  frame_err    out  1   1-cycle pulse: bad parity, bad stop, timeout, or code 00/FF
//  overflow     out  1   sticky: event dropped because FIFO was full
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0, FIFO empty, frame FSM IDLE, ext=brk=0, filters at 1.
//  Input path: 2-FF sync per line, then filter; filtered line toggles only after FILT_LEN equal samples.
//  fall = filtered clk 1->0, registered; cycle of fall = T.
//  Frame FSM (advances only on fall; data sampled = filtered data at T):
//   IDLE   : data=0 -> DATA, bitcnt=0; data=1 -> stay (no error)
//   DATA   : shift in LSB first; after 8th bit -> PARITY
//   PARITY : store bit; -> STOP
//   STOP   : odd parity over 8 data+parity AND stop=1 -> byte_ok; else frame_err; -> IDLE
//   Timeout: counter cleared on each fall and in IDLE; reaching TIMEOUT_CYC-1 outside IDLE ->
//            IDLE, frame_err, partial byte discarded; prefix flags preserved.
//  byte_ok registered at T+1 (STOP fall at T).
//  Prefix FSM (on byte_ok):
//   E0 -> ext=1;  F0 -> brk=1;  00/FF -> clear ext,brk, frame_err, no event;
//   other -> push {brk,ext,code}, clear ext,brk.
//  Push at T+2 edge; ev_valid/ev_data visible from T+2.
//  FIFO:
//   push when full and no rd_en -> event dropped, overflow=1;
//   push+rd_en same cycle when full -> both succeed; when empty -> push succeeds, pop ignored;
//   overflow clears on the cycle a pop leaves FIFO empty.
//   Pointers log2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSBs differ, rest equal.
//  Reset mid-frame: immediate return to IDLE; partial data and pending prefixes lost.
// STRUCTURE
//  ps2_pkg   : frame state enum, PS2_EXT=8'hE0, PS2_BRK=8'hF0, ev field indices (EV_BRK=9, EV_EXT=8).
//  ps2_line_filter : sync+FILT_LEN filter, instantiated twice (clk, data); reset value 1.
//  Frame FSM, prefix FSM and FIFO live in this module.
// TESTING (FILT_LEN=4, TIMEOUT_CYC=2000, FIFO_DEPTH=4; ps2 bit period 400 clk)
//  Frame 0x1C, parity 0, stop 1 -> one event 0x01C; ev_valid rises exactly 2 clk after the filtered stop fall.
//  Bytes F0,1C then E0,F0,75 -> events 0x21C then 0x375, in order; no event for prefix bytes.
//  0x1C with parity bit 1 -> frame_err pulse, no event, ext/brk unchanged.
//  Clock held high 2000 clk after 5th data bit -> frame_err; following good frame 0x32 -> event 0x032.
//  Push 5 events without rd_en -> 4 stored, overflow=1; rd_en at full concurrent with 6th push -> stays
//    full, order preserved; drain to empty -> overflow=0.
//  Glitch of 2 clk on ps2_clk -> no bit consumed; rst_n low mid-frame -> outputs 0, next frame decoded cleanly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 key front-end: frame states, prefix codes and event layout.
package ps2_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    typedef logic [1:0] frame_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int EV_W   = 10;
    localparam int EV_BRK = 9;
    localparam int EV_EXT = 8;

    typedef logic [EV_W-1:0] ps2_event_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a run-length filter; output idles high like the bus.
module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    localparam int CW = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Any sample agreeing with the current output restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            filt <= 1'b1;
        end else if (s2 == filt) begin
            cnt <= '0;
        end else if (cnt == CW'(FILT_LEN - 1)) begin
            cnt  <= '0;
            filt <= s2;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ps2_key_controller.sv
// PS/2 keyboard front-end: filtered frame receiver, E0/F0 prefix folding and a small
// first-word-fall-through event FIFO, all in the system clock domain.
module ps2_key_controller
    import ps2_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    input  logic            rd_en,
    output logic            ev_valid,
    output logic [EV_W-1:0] ev_data,
    output logic            frame_err,
    output logic            overflow
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic f_clk;
    logic f_data;
    logic f_clk_q;
    logic fall;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_clk (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (ps2_clk),
        .filt  (f_clk)
    );

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_data (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (ps2_data),
        .filt  (f_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_clk_q <= 1'b1;
            fall    <= 1'b0;
        end else begin
            f_clk_q <= f_clk;
            fall    <= f_clk_q & ~f_clk;
        end
    end

    // ---------------- frame receiver ----------------
    frame_state_t  state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tcnt;
    logic          byte_ok;
    logic          frame_bad;

    // A fall always wins over the timeout so a late but valid edge is still consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            tcnt      <= '0;
            byte_ok   <= 1'b0;
            frame_bad <= 1'b0;
        end else begin
            byte_ok   <= 1'b0;
            frame_bad <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (!f_data) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {f_data, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_bit <= f_data;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (parity_ok(shreg, par_bit) && f_data) byte_ok   <= 1'b1;
                        else                                     frame_bad <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state == ST_IDLE) begin
                tcnt <= '0;
            end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                state     <= ST_IDLE;
                tcnt      <= '0;
                frame_bad <= 1'b1;
            end else begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

    // ---------------- prefix folding ----------------
    logic       ext;
    logic       brk;
    logic       is_prefix;
    logic       code_bad;
    logic       push_req;
    ps2_event_t new_ev;

    always_comb begin
        is_prefix      = (shreg == PS2_EXT) || (shreg == PS2_BRK);
        code_bad       = byte_ok && ((shreg == 8'h00) || (shreg == 8'hFF));
        push_req       = byte_ok && !is_prefix && !code_bad;
        new_ev         = '0;
        new_ev[EV_BRK] = brk;
        new_ev[EV_EXT] = ext;
        new_ev[7:0]    = shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (byte_ok) begin
            case (shreg)
                PS2_EXT: ext <= 1'b1;
                PS2_BRK: brk <= 1'b1;
                default: begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_err <= 1'b0;
        else        frame_err <= frame_bad | code_bad;
    end

    // ---------------- event FIFO ----------------
    logic [FIFO_DEPTH-1:0][EV_W-1:0] mem;
    logic [AW:0]                     wr_ptr;
    logic [AW:0]                     rd_ptr;
    logic                            empty;
    logic                            full;
    logic                            pop;
    logic                            push_ok;
    logic                            last_out;

    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop      = rd_en && !empty;
        push_ok  = push_req && (!full || pop);
        last_out = pop && !push_ok && ((rd_ptr + (AW+1)'(1)) == wr_ptr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= new_ev;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push_req && full && !pop) overflow <= 1'b1;
            else if (last_out)            overflow <= 1'b0;
        end
    end

    assign ev_valid = !empty;
    assign ev_data  = mem[rd_ptr[AW-1:0]];

endmodule
